// File: rtl/mux_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mux_pipe_stage                                                |
// | Function : N-way operand select feeding a STAGES-deep register chain     |
// |            with valid, stall and flush. Optional sticky out-of-range     |
// |            select flag enabled by defining MUX_PIPE_SELERR_EN.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mux_pipe_stage #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int STAGES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid
`ifdef MUX_PIPE_SELERR_EN
    ,
    output logic                    sel_err
`endif
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (NUM_IN < 2) begin : g_err_num_in_low
        $error("mux_pipe_stage: NUM_IN must be at least 2");
    end
    if (NUM_IN > (1 << SEL_W)) begin : g_err_num_in_sel_w
        $error("mux_pipe_stage: NUM_IN exceeds 2**SEL_W");
    end
    if ((STAGES < 1) || (STAGES > 4)) begin : g_err_stages
        $error("mux_pipe_stage: STAGES must be within 1..4");
    end

    // ------------------------------------------------------------------
    // Input unpacking and combinational select
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_in [NUM_IN];
    logic [WIDTH-1:0] w_mux;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
        assign w_in[k] = in_bus[k*WIDTH +: WIDTH];
    end

    // No code matches when sel >= NUM_IN, so input 0 is the natural fallback.
    always_comb begin
        w_mux = w_in[0];
        for (int k = 1; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_mux = w_in[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Register chain: flush beats stall beats advance
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_data  [STAGES];
    logic             r_valid [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_data[i]  <= '0;
                r_valid[i] <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                r_data[i]  <= '0;
                r_valid[i] <= 1'b0;
            end
        end else if (!stall) begin
            r_data[0]  <= w_mux;
            r_valid[0] <= in_valid;
            // Invalid stages shift too; there is no bubble compaction.
            for (int i = 1; i < STAGES; i++) begin
                r_data[i]  <= r_data[i-1];
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    assign out       = r_data[STAGES-1];
    assign out_valid = r_valid[STAGES-1];

`ifdef MUX_PIPE_SELERR_EN
    // ------------------------------------------------------------------
    // Sticky out-of-range select flag, cleared only by reset
    // ------------------------------------------------------------------
    localparam logic [SEL_W:0] c_num_in = (SEL_W+1)'(NUM_IN);

    logic w_sel_oob;
    logic r_sel_err;

    assign w_sel_oob = ({1'b0, sel} >= c_num_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else if (!flush && !stall && in_valid && w_sel_oob) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;
`endif

endmodule
`default_nettype wire
